// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle right-shift controller wrapped around an external
//               8-bit single-step right-shift unit. Iterates the unit 0..7
//               times in logical, rotate, rotate-through-carry or arithmetic
//               mode, with a start/ready/done handshake.
// Options     : SHIFT_SEQ_BUSY_ERR_EN - when defined, builds a sticky flag
//               that records a start request arriving while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  input  logic             cin_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy_err,
  output logic [WIDTH-1:0] sh_x,
  output logic             sh_sel1,
  output logic             sh_sel0,
  output logic             sh_cin,
  input  logic [WIDTH-1:0] sh_f,
  input  logic             sh_cout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;

  logic w_accept;
  logic w_amt_zero;
  logic w_last_shift;

  assign w_accept     = start && (r_state == ST_IDLE);
  assign w_amt_zero   = (amt == '0);
  assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == AMT_W'(1));

  // The shift unit only ever sees registered values, so no input reaches it
  // combinationally and the external loop through sh_f cannot close.
  assign sh_x    = r_acc;
  assign sh_sel1 = r_mode[1];
  assign sh_sel0 = r_mode[0];
  assign sh_cin  = r_carry;

  assign ready = (r_state == ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign f     = r_f;
  assign cout  = r_cout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: a zero shift count skips straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_amt_zero ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, fold the unit result back each SHIFT cycle,
  // and publish the result on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_f     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= x_in;
      r_carry <= cin_in;
      r_cnt   <= amt;
      r_mode  <= mode;
      if (w_amt_zero) begin
        r_f    <= x_in;
        r_cout <= cin_in;
      end
    end else if (r_state == ST_SHIFT) begin
      r_acc   <= sh_f;
      r_carry <= sh_cout;
      r_cnt   <= r_cnt - AMT_W'(1);
      if (w_last_shift) begin
        r_f    <= sh_f;
        r_cout <= sh_cout;
      end
    end
  end

`ifdef SHIFT_SEQ_BUSY_ERR_EN
  logic r_busy_err;

  // Sticky collision flag: set by a request while busy, cleared by the next
  // request that is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_err <= 1'b0;
    end else if (start && !ready) begin
      r_busy_err <= 1'b1;
    end else if (w_accept) begin
      r_busy_err <= 1'b0;
    end
  end

  assign busy_err = r_busy_err;
`else
  assign busy_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Scoreboard bench for shift_sequencer with a behavioural model
//               of the single-step shift unit. Honours SHIFT_SEQ_BUSY_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] x_in;
  logic [2:0] amt;
  logic [1:0] mode;
  logic       cin_in;
  logic       ready;
  logic       done;
  logic [7:0] f;
  logic       cout;
  logic       busy_err;
  logic [7:0] sh_x;
  logic       sh_sel1;
  logic       sh_sel0;
  logic       sh_cin;
  logic [7:0] sh_f;
  logic       sh_cout;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_in     (x_in),
    .amt      (amt),
    .mode     (mode),
    .cin_in   (cin_in),
    .ready    (ready),
    .done     (done),
    .f        (f),
    .cout     (cout),
    .busy_err (busy_err),
    .sh_x     (sh_x),
    .sh_sel1  (sh_sel1),
    .sh_sel0  (sh_sel0),
    .sh_cin   (sh_cin),
    .sh_f     (sh_f),
    .sh_cout  (sh_cout)
  );

  always #5 clk = ~clk;

  // Single-step right-shift unit: fill bit chosen by mode, bit 0 falls out.
  always_comb begin
    sh_f    = {1'b0, sh_x[7:1]};
    sh_cout = sh_x[0];
    case ({sh_sel1, sh_sel0})
      2'b00:   sh_f = {1'b0,     sh_x[7:1]};
      2'b01:   sh_f = {sh_x[0],  sh_x[7:1]};
      2'b10:   sh_f = {sh_cin,   sh_x[7:1]};
      default: sh_f = {sh_x[7],  sh_x[7:1]};
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ef;
    logic       ec;
    int         ecyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0] x;
    logic [2:0] a;
    logic [1:0] m;
    logic       c;
    logic [7:0] ef;
    logic       ec;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result_f",    {24'd0, f},    {24'd0, e.ef});
        check("result_cout", {31'd0, cout}, {31'd0, e.ec});
        check("done_cycle",  cyc,           e.ecyc);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) timeout("wait_ready");
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input vec_t v);
    wait_ready();
    x_in   = v.x;
    amt    = v.a;
    mode   = v.m;
    cin_in = v.c;
    start  = 1'b1;
    q.push_back('{ef: v.ef, ec: v.ec, ecyc: cyc + int'(v.a) + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) timeout("drain");
  endtask

  vec_t vecs[10];
  logic exp_busy;

  initial begin
    vecs[0] = '{x: 8'hB5, a: 3'd3, m: 2'b00, c: 1'b0, ef: 8'h16, ec: 1'b1};
    vecs[1] = '{x: 8'hB5, a: 3'd3, m: 2'b01, c: 1'b0, ef: 8'hB6, ec: 1'b1};
    vecs[2] = '{x: 8'hB5, a: 3'd2, m: 2'b10, c: 1'b1, ef: 8'hED, ec: 1'b0};
    vecs[3] = '{x: 8'hB5, a: 3'd7, m: 2'b11, c: 1'b0, ef: 8'hFF, ec: 1'b0};
    vecs[4] = '{x: 8'hB5, a: 3'd0, m: 2'b00, c: 1'b0, ef: 8'hB5, ec: 1'b0};
    vecs[5] = '{x: 8'h4E, a: 3'd2, m: 2'b11, c: 1'b0, ef: 8'h13, ec: 1'b1};
    vecs[6] = '{x: 8'h81, a: 3'd1, m: 2'b01, c: 1'b0, ef: 8'hC0, ec: 1'b1};
    vecs[7] = '{x: 8'hF0, a: 3'd7, m: 2'b10, c: 1'b0, ef: 8'hC1, ec: 1'b1};
    vecs[8] = '{x: 8'h7F, a: 3'd7, m: 2'b00, c: 1'b1, ef: 8'h00, ec: 1'b1};
    vecs[9] = '{x: 8'h5A, a: 3'd0, m: 2'b10, c: 1'b1, ef: 8'h5A, ec: 1'b1};

`ifdef SHIFT_SEQ_BUSY_ERR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    x_in   = '0;
    amt    = '0;
    mode   = '0;
    cin_in = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready",    {31'd0, ready},    32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_f",        {24'd0, f},        32'd0);
    check("rst_cout",     {31'd0, cout},     32'd0);
    check("rst_busy_err", {31'd0, busy_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations, issued back to back
    for (int i = 0; i < 10; i++) issue(vecs[i]);
    drain();

    // Reset in the middle of a long shift: outputs clear at once, no done
    issue('{x: 8'hB5, a: 3'd7, m: 2'b11, c: 1'b0, ef: 8'hFF, ec: 1'b0});
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_f",     {24'd0, f},     32'd0);
    check("midrst_cout",  {31'd0, cout},  32'd0);
    check("midrst_done",  {31'd0, done},  32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue('{x: 8'h96, a: 3'd4, m: 2'b01, c: 1'b0, ef: 8'h69, ec: 1'b0});
    drain();

    // Collision: a start pulse during SHIFT is ignored
    issue('{x: 8'hB5, a: 3'd5, m: 2'b00, c: 1'b0, ef: 8'h05, ec: 1'b1});
    @(negedge clk);
    x_in  = 8'hFF;
    amt   = 3'd0;
    mode  = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_err_set", {31'd0, busy_err}, {31'd0, exp_busy});
    drain();
    check("busy_err_sticky", {31'd0, busy_err}, {31'd0, exp_busy});
    issue('{x: 8'h3C, a: 3'd0, m: 2'b00, c: 1'b1, ef: 8'h3C, ec: 1'b1});
    check("busy_err_clear", {31'd0, busy_err}, 32'd0);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle right-shift controller that sits directly upstream of the team's 8-bit single-step right-shift unit. It drives the unit's operand, mode selects and carry-in, and captures the unit's result and carry-out back into its accumulator each cycle. Iterating the unit this way gives 0–7 position shifts in four modes: logical, rotate, rotate-through-carry and arithmetic. A start/ready/done handshake serves the surrounding datapath.

## Interface
Parameters:
- WIDTH, 8, operand width; only 8 is supported, to match the shift unit.
- AMT_W, 3, shift-amount width; maximum shift is 2^AMT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only on a rising edge where ready=1
- x_in  in  WIDTH  operand, sampled at acceptance
- amt  in  AMT_W  shift count 0..7, sampled at acceptance
- mode  in  2  {sel1,sel0}: 00 logical (0 fill), 01 rotate, 10 through carry, 11 arithmetic; sampled at acceptance
- cin_in  in  1  initial carry, sampled at acceptance
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; result valid
- f  out  WIDTH  result register
- cout  out  1  carry flag register (last bit shifted out)
- busy_err  out  1  sticky collision flag (see Configuration)
- sh_x  out  WIDTH  operand to shift unit (= acc)
- sh_sel1, sh_sel0  out  1 each  mode to shift unit (= latched mode)
- sh_cin  out  1  carry to shift unit (= carry register)
- sh_f  in  WIDTH  shift unit result
- sh_cout  in  1  shift unit carry-out (operand bit 0)

## Operation
- Internal registers:
  - acc[WIDTH]
  - carry
  - cnt[AMT_W]
  - mode_q[2]
  - state ∈ {IDLE, SHIFT, DONE}
- Reset (asynchronous, any state):
  - state=IDLE, acc=0, carry=0, cnt=0, mode_q=0.
  - Outputs: f=0, cout=0, done=0, busy_err=0, ready=1.
  - An in-flight operation is discarded and produces no done.
- IDLE, start=1:
  - Load acc←x_in, carry←cin_in, cnt←amt, mode_q←mode.
  - amt≠0 → next state SHIFT; amt=0 → next state DONE.
- SHIFT, each edge:
  - acc←sh_f, carry←sh_cout, cnt←cnt-1.
  - If cnt=1, next state is DONE.
- Entry to DONE (same edge): f←final acc value, cout←final carry value.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- f and cout hold their values until the next DONE entry or reset.
- start while ready=0 (SHIFT or DONE) is ignored; no queuing.
- Result equivalence:
  - Mode 01: amt-position rotate right.
  - Mode 10: amt-position rotate of the 9-bit value {cin_in, x_in}.
  - Mode 11: sign replication of x_in[7].
  - All modes: cout is x_in[amt-1] when amt≠0, and cin_in when amt=0.
- sh_* outputs are purely combinational from registers, with no input→output paths.

## Timing
- Acceptance edge E0. The shifts occur on E1..E_amt. done is high in the cycle after edge E_amt; for amt=0, the cycle after E0.
- Latency from acceptance to done: amt+1 cycles. ready returns high one cycle after done.
- Back-to-back throughput: one operation per amt+2 cycles.
- done and the updated f/cout become visible together, after the same edge.
- Reset deassertion: the first possible acceptance is the first rising edge with rst_n=1.

## Configuration
- SHIFT_SEQ_BUSY_ERR_EN
  - Defined: busy_err is set on any edge where start=1 and ready=0. It is cleared on the next accepted start and on reset.
  - Undefined: busy_err is tied to 0 and no detection logic is built. All other behaviour is identical in both builds.

## Test plan
- Logical shift: x_in=10110101, mode=00, amt=3 → done 4 cycles after acceptance; f=00010110, cout=1.
- Rotate: x_in=10110101, mode=01, amt=3 → f=10110110, cout=1.
- Through carry: x_in=10110101, mode=10, cin_in=1, amt=2 → f=11101101, cout=0.
- Arithmetic and zero shift:
  - x_in=10110101, mode=11, amt=7 → f=11111111, cout=0, done 8 cycles after acceptance.
  - amt=0, cin_in=0 → f=10110101, cout=0, done 1 cycle after acceptance.
- Reset mid-operation:
  - Drop rst_n during SHIFT → immediately f=0, cout=0, done=0, ready=1.
  - No done pulse follows; a new start after release completes normally.
- Collision (macro defined): pulse start during SHIFT → the pulse is ignored, the original result is unchanged and busy_err=1. busy_err clears on the next accepted start. With the macro undefined, busy_err stays 0.
